// File: rtl/br_amba_axil2apb_bridge.sv
// AXI4-Lite to APB4 requester bridge.
// One transaction in flight; round-robin read/write arbitration in IDLE,
// followed by an APB SETUP/ACCESS pair and an AXI response phase.
module br_amba_axil2apb_bridge #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AddrWidth-1:0]     axil_awaddr,
  input  logic [2:0]               axil_awprot,
  input  logic                     axil_awvalid,
  output logic                     axil_awready,
  input  logic [DataWidth-1:0]     axil_wdata,
  input  logic [DataWidth/8-1:0]   axil_wstrb,
  input  logic                     axil_wvalid,
  output logic                     axil_wready,
  output logic [1:0]               axil_bresp,
  output logic                     axil_bvalid,
  input  logic                     axil_bready,
  input  logic [AddrWidth-1:0]     axil_araddr,
  input  logic [2:0]               axil_arprot,
  input  logic                     axil_arvalid,
  output logic                     axil_arready,
  output logic [DataWidth-1:0]     axil_rdata,
  output logic [1:0]               axil_rresp,
  output logic                     axil_rvalid,
  input  logic                     axil_rready,
  output logic [AddrWidth-1:0]     apb_paddr,
  output logic                     apb_psel,
  output logic                     apb_penable,
  output logic [2:0]               apb_pprot,
  output logic                     apb_pwrite,
  output logic [DataWidth-1:0]     apb_pwdata,
  output logic [DataWidth/8-1:0]   apb_pstrb,
  input  logic [DataWidth-1:0]     apb_prdata,
  input  logic                     apb_pready,
  input  logic                     apb_pslverr
);

  localparam int StrobeWidth = DataWidth / 8;

  // Elaboration-time guard on legal parameter values.
  if (AddrWidth < 12) begin : g_bad_addr
    $error("br_amba_axil2apb_bridge: AddrWidth must be at least 12");
  end
  if (DataWidth != 8 && DataWidth != 16 && DataWidth != 32) begin : g_bad_data
    $error("br_amba_axil2apb_bridge: DataWidth must be 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     last_wr_q, last_wr_d;
  logic [AddrWidth-1:0]     paddr_q, paddr_d;
  logic [2:0]               pprot_q, pprot_d;
  logic                     pwrite_q, pwrite_d;
  logic [DataWidth-1:0]     pwdata_q, pwdata_d;
  logic [StrobeWidth-1:0]   pstrb_q, pstrb_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [1:0]               rresp_q, rresp_d;
  logic [DataWidth-1:0]     rdata_q, rdata_d;

  logic wr_cand, rd_cand, rd_win, wr_win;

  // Map the APB slave error flag onto an AXI response code.
  function automatic logic [1:0] slverr_to_resp(input logic slverr);
    return slverr ? 2'b10 : 2'b00;
  endfunction

  // A write needs both AW and W present; a lone candidate always wins,
  // a contest goes to whichever side was not served last.
  always_comb begin
    wr_cand = axil_awvalid & axil_wvalid;
    rd_cand = axil_arvalid;
    rd_win  = rd_cand & (~wr_cand | last_wr_q);
    wr_win  = wr_cand & ~rd_win;
  end

  // Next-state and datapath register selection for the transfer FSM.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (rd_win) begin
          paddr_d   = axil_araddr;
          pprot_d   = axil_arprot;
          pwrite_d  = 1'b0;
          pwdata_d  = '0;
          pstrb_d   = '0;
          last_wr_d = 1'b0;
          state_d   = SETUP;
        end else if (wr_win) begin
          paddr_d   = axil_awaddr;
          pprot_d   = axil_awprot;
          pwrite_d  = 1'b1;
          pwdata_d  = axil_wdata;
          pstrb_d   = axil_wstrb;
          last_wr_d = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb_pready) begin
          if (pwrite_q) begin
            bresp_d = slverr_to_resp(apb_pslverr);
          end else begin
            rresp_d = slverr_to_resp(apb_pslverr);
            rdata_d = apb_prdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        // No new accept in the exit cycle: IDLE is only entered next cycle.
        if (pwrite_q ? axil_bready : axil_rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset aborts any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      paddr_q   <= paddr_d;
      pprot_q   <= pprot_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Handshake and APB control outputs decoded from state.
  always_comb begin
    axil_awready = (state_q == IDLE) & wr_win;
    axil_wready  = (state_q == IDLE) & wr_win;
    axil_arready = (state_q == IDLE) & rd_win;
    apb_psel     = (state_q == SETUP) | (state_q == ACCESS);
    apb_penable  = (state_q == ACCESS);
    axil_bvalid  = (state_q == RESP) & pwrite_q;
    axil_rvalid  = (state_q == RESP) & ~pwrite_q;
  end

  assign apb_paddr  = paddr_q;
  assign apb_pprot  = pprot_q;
  assign apb_pwrite = pwrite_q;
  assign apb_pwdata = pwdata_q;
  assign apb_pstrb  = pstrb_q;
  assign axil_bresp = bresp_q;
  assign axil_rresp = rresp_q;
  assign axil_rdata = rdata_q;

endmodule

// File: tb/tb_br_amba_axil2apb_bridge.sv
// Scoreboard testbench for br_amba_axil2apb_bridge.
module tb_br_amba_axil2apb_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] axil_awaddr = '0;
  logic [2:0]    axil_awprot = '0;
  logic          axil_awvalid = 1'b0;
  logic          axil_awready;
  logic [DW-1:0] axil_wdata = '0;
  logic [SW-1:0] axil_wstrb = '0;
  logic          axil_wvalid = 1'b0;
  logic          axil_wready;
  logic [1:0]    axil_bresp;
  logic          axil_bvalid;
  logic          axil_bready = 1'b1;
  logic [AW-1:0] axil_araddr = '0;
  logic [2:0]    axil_arprot = '0;
  logic          axil_arvalid = 1'b0;
  logic          axil_arready;
  logic [DW-1:0] axil_rdata;
  logic [1:0]    axil_rresp;
  logic          axil_rvalid;
  logic          axil_rready = 1'b1;
  logic [AW-1:0] apb_paddr;
  logic          apb_psel;
  logic          apb_penable;
  logic [2:0]    apb_pprot;
  logic          apb_pwrite;
  logic [DW-1:0] apb_pwdata;
  logic [SW-1:0] apb_pstrb;
  logic [DW-1:0] apb_prdata = '0;
  logic          apb_pready = 1'b0;
  logic          apb_pslverr = 1'b0;

  int cfg_ws = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
  } apb_t;

  typedef struct packed {
    logic          wr;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  apb_t apb_q[$];
  rsp_t rsp_q[$];
  apb_t ea;
  rsp_t er;

  br_amba_axil2apb_bridge #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst(rst),
    .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot),
    .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
    .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb),
    .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
    .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready),
    .axil_araddr(axil_araddr), .axil_arprot(axil_arprot),
    .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
    .axil_rdata(axil_rdata), .axil_rresp(axil_rresp),
    .axil_rvalid(axil_rvalid), .axil_rready(axil_rready),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pprot(apb_pprot), .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
    .apb_pstrb(apb_pstrb), .apb_prdata(apb_prdata), .apb_pready(apb_pready),
    .apb_pslverr(apb_pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // APB slave: inserts cfg_ws wait states per ACCESS, updated just after each edge.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (apb_psel && !apb_penable) begin
        wcnt = cfg_ws;
        apb_pready = 1'b0;
      end else if (apb_psel && apb_penable) begin
        if (wcnt == 0) apb_pready = 1'b1;
        else begin
          wcnt--;
          apb_pready = 1'b0;
        end
      end else begin
        apb_pready = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes an APB transfer or a response.
  always @(negedge clk) begin
    if (!rst) begin
      if (apb_psel && apb_penable && apb_pready) begin
        if (apb_q.size() == 0) chk("apb_unexpected", 64'(1), 64'(0));
        else begin
          ea = apb_q.pop_front();
          chk("apb_pwrite", 64'(apb_pwrite), 64'(ea.wr));
          chk("apb_paddr", 64'(apb_paddr), 64'(ea.addr));
          chk("apb_pwdata", 64'(apb_pwdata), 64'(ea.wdata));
          chk("apb_pstrb", 64'(apb_pstrb), 64'(ea.strb));
          chk("apb_pprot", 64'(apb_pprot), 64'(ea.prot));
        end
      end
      if (axil_bvalid && axil_bready) begin
        if (rsp_q.size() == 0) chk("b_unexpected", 64'(1), 64'(0));
        else begin
          er = rsp_q.pop_front();
          chk("b_kind", 64'(1), 64'(er.wr));
          chk("bresp", 64'(axil_bresp), 64'(er.resp));
        end
      end
      if (axil_rvalid && axil_rready) begin
        if (rsp_q.size() == 0) chk("r_unexpected", 64'(1), 64'(0));
        else begin
          er = rsp_q.pop_front();
          chk("r_kind", 64'(0), 64'(er.wr));
          chk("rdata", 64'(axil_rdata), 64'(er.rdata));
          chk("rresp", 64'(axil_rresp), 64'(er.resp));
        end
      end
    end
  end

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [2:0] p, input logic err);
    apb_q.push_back('{wr: 1'b1, addr: a, wdata: d, strb: s, prot: p});
    rsp_q.push_back('{wr: 1'b1, rdata: '0, resp: err ? 2'b10 : 2'b00});
  endtask

  task automatic exp_rd(input logic [AW-1:0] a, input logic [2:0] p,
                        input logic [DW-1:0] d, input logic err);
    apb_q.push_back('{wr: 1'b0, addr: a, wdata: '0, strb: '0, prot: p});
    rsp_q.push_back('{wr: 1'b0, rdata: d, resp: err ? 2'b10 : 2'b00});
  endtask

  // Drivers are entered and left just after a rising edge.
  task automatic wr_drv(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [2:0] p);
    bit done;
    done = 1'b0;
    axil_awaddr = a; axil_awprot = p; axil_wdata = d; axil_wstrb = s;
    axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (axil_awready && axil_wready) done = 1'b1;
      @(posedge clk); #1;
    end
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    if (!done) chk("wr_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic rd_drv(input logic [AW-1:0] a, input logic [2:0] p);
    bit done;
    done = 1'b0;
    axil_araddr = a; axil_arprot = p; axil_arvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (axil_arready) done = 1'b1;
      @(posedge clk); #1;
    end
    axil_arvalid = 1'b0;
    if (!done) chk("rd_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (apb_q.size() == 0 && rsp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (apb_q.size() != 0 || rsp_q.size() != 0) chk("drain_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_psel", 64'(apb_psel), 64'(0));
    chk("rst_penable", 64'(apb_penable), 64'(0));
    chk("rst_paddr", 64'(apb_paddr), 64'(0));
    chk("rst_pwrite", 64'(apb_pwrite), 64'(0));
    chk("rst_pwdata", 64'(apb_pwdata), 64'(0));
    chk("rst_pstrb", 64'(apb_pstrb), 64'(0));
    chk("rst_bvalid", 64'(axil_bvalid), 64'(0));
    chk("rst_rvalid", 64'(axil_rvalid), 64'(0));
    chk("rst_bresp", 64'(axil_bresp), 64'(0));
    chk("rst_rresp", 64'(axil_rresp), 64'(0));
    chk("rst_rdata", 64'(axil_rdata), 64'(0));
    chk("rst_awready", 64'(axil_awready), 64'(0));
    chk("rst_arready", 64'(axil_arready), 64'(0));
    @(posedge clk); #1;

    // Single write with zero wait states, cycle-by-cycle timing
    cfg_ws = 0; apb_pslverr = 1'b0;
    exp_wr(12'h010, 32'hDEADBEEF, 4'b0011, 3'b010, 1'b0);
    axil_awaddr = 12'h010; axil_awprot = 3'b010; axil_wdata = 32'hDEADBEEF;
    axil_wstrb = 4'b0011; axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    @(negedge clk);
    chk("w1_awready_c0", 64'(axil_awready), 64'(1));
    chk("w1_wready_c0", 64'(axil_wready), 64'(1));
    @(posedge clk); #1;
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    @(negedge clk);
    chk("w1_psel_c1", 64'(apb_psel), 64'(1));
    chk("w1_penable_c1", 64'(apb_penable), 64'(0));
    chk("w1_pwrite_c1", 64'(apb_pwrite), 64'(1));
    chk("w1_pstrb_c1", 64'(apb_pstrb), 64'(4'b0011));
    @(negedge clk);
    chk("w1_penable_c2", 64'(apb_penable), 64'(1));
    @(negedge clk);
    chk("w1_bvalid_c3", 64'(axil_bvalid), 64'(1));
    chk("w1_psel_c3", 64'(apb_psel), 64'(0));
    @(posedge clk); #1;
    wait_done();

    // Read with 3 wait states and a slave error
    cfg_ws = 3; apb_prdata = 32'h12345678; apb_pslverr = 1'b1;
    exp_rd(12'h0A4, 3'b001, 32'h12345678, 1'b1);
    rd_drv(12'h0A4, 3'b001);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (axil_rvalid) seen = 1'b1;
      else if (apb_penable) begin
        cnt++;
        chk("r2_paddr_stable", 64'(apb_paddr), 64'(12'h0A4));
      end
    end
    chk("r2_penable_cycles", 64'(cnt), 64'(4));
    chk("r2_rvalid_seen", 64'(seen), 64'(1));
    @(posedge clk); #1;
    wait_done();

    // AW without W is held off
    cfg_ws = 0; apb_pslverr = 1'b0;
    exp_wr(12'h024, 32'h0BADF00D, 4'b1111, 3'b000, 1'b0);
    axil_awaddr = 12'h024; axil_awprot = 3'b000; axil_wdata = 32'h0BADF00D;
    axil_wstrb = 4'b1111; axil_awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("aw_only_awready", 64'(axil_awready), 64'(0));
      chk("aw_only_psel", 64'(apb_psel), 64'(0));
      @(posedge clk); #1;
    end
    axil_wvalid = 1'b1;
    @(negedge clk);
    chk("aw_w_awready", 64'(axil_awready), 64'(1));
    chk("aw_w_wready", 64'(axil_wready), 64'(1));
    @(posedge clk); #1;
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    wait_done();

    // Simultaneous read and write, four rounds: read wins each contest
    apb_prdata = 32'hA5A50F0F;
    for (int i = 0; i < 4; i++) begin
      exp_rd(12'(12'h200 + 4 * i), 3'b001, 32'hA5A50F0F, 1'b0);
      exp_wr(12'(12'h100 + 4 * i), 32'h1000 + 32'(i), 4'b1111, 3'b100, 1'b0);
      fork
        wr_drv(12'(12'h100 + 4 * i), 32'h1000 + 32'(i), 4'b1111, 3'b100);
        rd_drv(12'(12'h200 + 4 * i), 3'b001);
      join
      wait_done();
    end

    // Back-pressure on B; a pending read waits for the handshake
    apb_pslverr = 1'b1; apb_prdata = 32'h55AA1234; axil_bready = 1'b0;
    exp_wr(12'h300, 32'h11223344, 4'b1111, 3'b000, 1'b1);
    exp_rd(12'h040, 3'b000, 32'h55AA1234, 1'b1);
    wr_drv(12'h300, 32'h11223344, 4'b1111, 3'b000);
    axil_araddr = 12'h040; axil_arprot = 3'b000; axil_arvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (axil_bvalid) seen = 1'b1;
    end
    chk("bp_bvalid_seen", 64'(seen), 64'(1));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      chk("bp_bvalid_hold", 64'(axil_bvalid), 64'(1));
      chk("bp_bresp_hold", 64'(axil_bresp), 64'(2'b10));
      chk("bp_arready_low", 64'(axil_arready), 64'(0));
    end
    @(posedge clk); #1;
    axil_bready = 1'b1;
    @(negedge clk);
    chk("bp_arready_hs_cycle", 64'(axil_arready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_arready_after", 64'(axil_arready), 64'(1));
    @(posedge clk); #1;
    axil_arvalid = 1'b0;
    wait_done();
    apb_pslverr = 1'b0;

    // Reset during ACCESS aborts the write, then a read completes
    cfg_ws = 20;
    wr_drv(12'h500, 32'hFEEDFACE, 4'b1111, 3'b000);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (apb_penable) seen = 1'b1;
    end
    chk("abort_access_seen", 64'(seen), 64'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_psel", 64'(apb_psel), 64'(0));
    chk("abort_penable", 64'(apb_penable), 64'(0));
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_bvalid", 64'(axil_bvalid), 64'(0));
      chk("abort_no_rvalid", 64'(axil_rvalid), 64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    cfg_ws = 1; apb_prdata = 32'h600DCAFE;
    exp_rd(12'h07C, 3'b011, 32'h600DCAFE, 1'b0);
    rd_drv(12'h07C, 3'b011);
    wait_done();

    chk("apb_q_empty", 64'(apb_q.size()), 64'(0));
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/br_amba_axil2apb_bridge.md
Name: br_amba_axil2apb_bridge

Overview:
Consumes the AXI4-Lite output of the AXI4-to-AXI4-Lite bridge and converts it to an APB4 requester port for low-speed register slaves. One transaction is in flight at a time, with read/write arbitration and a SETUP/ACCESS/RESP state machine.

Parameters:
AddrWidth, 12, AXI4-Lite/APB address width; must be at least 12.
DataWidth, 32, data width; must be 8, 16 or 32. StrobeWidth = DataWidth/8 is a localparam.

Ports:
clk  input  1  clock.
rst  input  1  reset; synchronous, active-high.
axil_awaddr  input  AddrWidth  write address.
axil_awprot  input  3  write protection.
axil_awvalid  input  1  write address valid.
axil_awready  output  1  write address ready.
axil_wdata  input  DataWidth  write data.
axil_wstrb  input  StrobeWidth  write byte strobes.
axil_wvalid  input  1  write data valid.
axil_wready  output  1  write data ready.
axil_bresp  output  2  write response.
axil_bvalid  output  1  write response valid.
axil_bready  input  1  write response ready.
axil_araddr  input  AddrWidth  read address.
axil_arprot  input  3  read protection.
axil_arvalid  input  1  read address valid.
axil_arready  output  1  read address ready.
axil_rdata  output  DataWidth  read data.
axil_rresp  output  2  read response.
axil_rvalid  output  1  read data valid.
axil_rready  input  1  read data ready.
apb_paddr  output  AddrWidth  APB address.
apb_psel  output  1  APB select.
apb_penable  output  1  APB enable.
apb_pprot  output  3  APB protection; copied from awprot or arprot.
apb_pwrite  output  1  1 = write.
apb_pwdata  output  DataWidth  APB write data.
apb_pstrb  output  StrobeWidth  APB strobes; all zero for reads.
apb_prdata  input  DataWidth  APB read data.
apb_pready  input  1  APB ready.
apb_pslverr  input  1  APB slave error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE. All outputs reset to 0, including bresp, rresp and rdata.
- IDLE, write candidate: exists only when awvalid and wvalid are both high. awready and wready are asserted together, in the same cycle, only in IDLE when the write wins. An AW without W, or W without AW, is never accepted.
- IDLE, read candidate: exists when arvalid is high. arready is asserted only in IDLE when the read wins.
- Arbitration, both candidates present: round-robin. The last-served flag resets to "write served", so the first contest goes to the read. A lone candidate always wins.
- On accept: register paddr, pprot, pwrite, pwdata and pstrb (reads: pstrb=0, pwdata=0), then go to SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. Hold every APB output stable until pready=1. pready ignores prdata/pslverr when low; there are unbounded wait states and no timeout.
- On pready in ACCESS: resp = pslverr ? 2'b10 (SLVERR) : 2'b00 (OKAY). Reads register prdata into rdata. Next cycle: psel=0, penable=0, state RESP.
- RESP: drive bvalid (write) or rvalid (read) with stable resp/data until bready/rready; then return to IDLE. No accept happens in the RESP exit cycle.
- Minimum latency, accept to response valid: 3 cycles (accept c0, SETUP c1, ACCESS+pready c2, valid c3). Peak throughput: 1 transaction per 4 cycles.
- Reset mid-transaction: synchronous abort to IDLE. psel, penable, valids and readies are 0 the cycle after rst is sampled, and no response is issued for the aborted transaction.
- Ready signals depend combinationally on valids and state only, never on bready, rready or pready.

Test Plan:
- Single write: aw=0x010, wdata=0xDEADBEEF, wstrb=4'b0011, pready=1 immediately -> psel c1, penable c2, pwrite=1, pstrb=0011; bvalid c3 with bresp=00.
- Read with 3 wait states, prdata=0x12345678, pslverr=1 -> penable held 4 cycles with paddr stable; rvalid with rdata=0x12345678, rresp=10.
- AW valid without W for 5 cycles -> awready=0 and psel=0 throughout; W arrives -> awready=wready=1 in the same cycle.
- AW+W and AR valid simultaneously, repeated 4 times -> APB order read, write, read, write.
- bready held low 6 cycles -> bvalid and bresp stable; arvalid not accepted until the cycle after the bvalid&bready handshake.
- rst asserted during ACCESS -> psel=penable=0 next cycle, no bvalid/rvalid; a following read completes normally.
